// File: rtl/key_uart_pkg.sv
// Shared types and constants for the key-to-UART scheduler.
package key_uart_pkg;

    localparam int         NUM_KEYS = 4;
    localparam logic [7:0] LF_CHAR  = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        REQ_KEY,
        WAIT_KEY,
        REQ_LF,
        WAIT_LF
    } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter over four requesters.
// Search starts one past the last granted index and wraps.
module rr_arbiter4
    import key_uart_pkg::*;
(
    input  logic [NUM_KEYS-1:0] req,
    input  logic [1:0]          ptr,
    output logic [1:0]          gnt_idx,
    output logic                gnt_any
);

    logic [1:0] cand;

    // First pending requester found walking forward from ptr+1.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_KEYS; k++) begin
            cand = ptr + 2'(k);
            if (!gnt_any && req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_tx_sched.sv
// Key press scheduler feeding a single UART transmitter.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | no frame in flight; grant the next pending key
// REQ_KEY  | waiting for tx_ready to launch the key character
// WAIT_KEY | key character on the line; waiting for tx_done
// REQ_LF   | waiting for tx_ready to launch the line feed
// WAIT_LF  | line feed on the line; waiting for tx_done
module key_tx_sched
    import key_uart_pkg::*;
#(
    parameter logic [7:0] CHAR_BASE = 8'h31,
    parameter bit         LF_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                tx_ready,
    input  logic                tx_done,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic [NUM_KEYS-1:0] overrun
);

    state_t              state, state_nxt;
    logic [NUM_KEYS-1:0] key_d;
    logic [NUM_KEYS-1:0] pend;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] pend_clr;
    logic [1:0]          ptr, ptr_nxt;
    logic [1:0]          gnt, gnt_nxt;
    logic [1:0]          arb_idx;
    logic                arb_any;
    logic                take;
    logic                start_nxt;
    logic [7:0]          data_nxt;
    logic                valid_nxt;

    assign rise     = key_in & ~key_d;
    assign pend_clr = take ? (NUM_KEYS'(1) << arb_idx) : '0;

    rr_arbiter4 u_arb (
        .req     (pend),
        .ptr     (ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Edge detect, pending flags and sticky overrun. A rise landing on the
    // grant cycle re-arms pend without counting as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_d   <= '0;
            pend    <= '0;
            overrun <= '0;
        end else begin
            key_d   <= key_in;
            pend    <= (pend & ~pend_clr) | rise;
            overrun <= overrun | (rise & pend & ~pend_clr);
        end
    end

    // State register and registered UART-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            gnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            tx_start <= start_nxt;
            tx_data  <= data_nxt;
            tx_valid <= valid_nxt;
        end
    end

    // Next-state and next-output decode; tx_done only matters in WAIT_*.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        take      = 1'b0;
        start_nxt = 1'b0;
        data_nxt  = tx_data;
        valid_nxt = tx_valid;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    take      = 1'b1;
                    gnt_nxt   = arb_idx;
                    ptr_nxt   = arb_idx;
                    valid_nxt = 1'b1;
                    state_nxt = REQ_KEY;
                end
            end
            REQ_KEY: begin
                if (tx_ready) begin
                    start_nxt = 1'b1;
                    data_nxt  = CHAR_BASE + {6'd0, gnt};
                    state_nxt = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (tx_done) begin
                    if (LF_EN) begin
                        state_nxt = REQ_LF;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            REQ_LF: begin
                if (tx_ready) begin
                    start_nxt = 1'b1;
                    data_nxt  = LF_CHAR;
                    state_nxt = WAIT_LF;
                end
            end
            WAIT_LF: begin
                if (tx_done) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_tx_sched.sv
// Bench for key_tx_sched: UART model, transaction-level expected byte stream.
module tb_key_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] overrun;

    int nchk = 0;
    int nerr = 0;

    key_tx_sched dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .overrun  (overrun)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART model state and observation log
    logic [7:0] q_bytes[$];
    int         start_cyc[$];
    logic [7:0] exp_q[$];
    bit         busy = 1'b0;
    bit         stall = 1'b0;
    bit         valid_prev = 1'b0;
    int         cnt = 0;
    int         frame_len = 10;
    int         done_cyc = -1;
    int         ready_rise_cyc = -1;
    int         valid_fall_cyc = -1;
    int         proto_viol = 0;
    int         mptr = 3;

    // UART TX model: accepts a byte on tx_start, busy for frame_len cycles,
    // pulses tx_done at the end. Not affected by the scheduler reset.
    initial begin
        tx_ready = 1'b1;
        tx_done  = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_start === 1'b1) begin
                if (tx_ready !== 1'b1 || busy) proto_viol++;
                q_bytes.push_back(tx_data);
                start_cyc.push_back(cyc);
                busy = 1'b1;
                cnt  = frame_len;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy     = 1'b0;
                    tx_done  = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (!busy && !stall && tx_ready !== 1'b1) ready_rise_cyc = cyc;
            tx_ready = !busy && !stall;
            if (valid_prev && tx_valid === 1'b0) valid_fall_cyc = cyc;
            valid_prev = (tx_valid === 1'b1);
        end
    end

    // Expected bytes for a set of keys pending together, served round-robin
    // from the model pointer; advances the model pointer.
    task automatic build_expected(input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (mptr + k) % 4;
            if (mask[i]) begin
                exp_q.push_back(8'h31 + 8'(i));
                exp_q.push_back(8'h0A);
            end
        end
        for (int k = 4; k >= 1; k--) begin
            int i;
            i = (mptr + k) % 4;
            if (mask[i]) begin
                mptr = i;
                break;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        q_bytes.delete();
        start_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick(1);
            if (q_bytes.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick(1);
            if (tx_valid === 1'b0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick(4);
    endtask

    task automatic apply_reset();
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        mptr = 3;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        key_in = 4'b0000;
        tick(3);
        nchk++;
        if (tx_start !== 1'b0 || tx_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ctl: tx_start=%b tx_valid=%b, want 0 0", tx_start, tx_valid);
        end
        nchk++;
        if (tx_data !== 8'h00) begin
            nerr++;
            $display("FAIL reset_data: got %h want 00", tx_data);
        end
        nchk++;
        if (overrun !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_overrun: got %b want 0000", overrun);
        end
        rst = 1'b0;
        mptr = 3;
        clear_log();
        tick(5);
        nchk++;
        if (q_bytes.size() != 0) begin
            nerr++;
            $display("FAIL reset_quiet: got %0d starts want 0", q_bytes.size());
        end
    endtask

    task automatic test_single_press();
        int c0;
        bit ok;
        clear_log();
        frame_len = 10;
        build_expected(4'b0001);
        tick(1);
        c0 = cyc;
        key_in = 4'b0001;
        wait_starts(2, 200, ok);
        wait_idle(200, ok);
        nchk++;
        if (q_bytes.size() != 2) begin
            nerr++;
            $display("FAIL single_count: got %0d bytes want 2", q_bytes.size());
        end else begin
            nchk++;
            if (q_bytes[0] !== exp_q[0] || q_bytes[1] !== exp_q[1]) begin
                nerr++;
                $display("FAIL single_bytes: got %h %h want %h %h", q_bytes[0], q_bytes[1], exp_q[0], exp_q[1]);
            end
            nchk++;
            if (start_cyc[0] - c0 != 3) begin
                nerr++;
                $display("FAIL single_latency: got %0d cycles want 3", start_cyc[0] - c0);
            end
        end
        nchk++;
        if (valid_fall_cyc != done_cyc + 1) begin
            nerr++;
            $display("FAIL single_valid_drop: fell at %0d want %0d", valid_fall_cyc, done_cyc + 1);
        end
        key_in = 4'b0000;
        tick(2);
    endtask

    task automatic test_simultaneous();
        bit ok;
        apply_reset();
        clear_log();
        build_expected(4'b1111);
        key_in = 4'b1111;
        wait_starts(8, 400, ok);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL simul_timeout: got %0d bytes want 8", q_bytes.size());
        end
        wait_idle(200, ok);
        nchk++;
        if (q_bytes.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL simul_count: got %0d want %0d", q_bytes.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                nchk++;
                if (q_bytes[i] !== exp_q[i]) begin
                    nerr++;
                    $display("FAIL simul_byte%0d: got %h want %h", i, q_bytes[i], exp_q[i]);
                end
            end
        end
        nchk++;
        if (overrun !== 4'b0000) begin
            nerr++;
            $display("FAIL simul_overrun: got %b want 0000", overrun);
        end
        key_in = 4'b0000;
        tick(2);
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_log();
        build_expected(4'b0100);
        build_expected(4'b1001);
        key_in = 4'b0100;
        wait_starts(1, 100, ok);
        tick(2);
        key_in = 4'b1101;
        wait_starts(6, 400, ok);
        wait_idle(200, ok);
        nchk++;
        if (q_bytes.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL rr_count: got %0d want %0d", q_bytes.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                nchk++;
                if (q_bytes[i] !== exp_q[i]) begin
                    nerr++;
                    $display("FAIL rr_byte%0d: got %h want %h", i, q_bytes[i], exp_q[i]);
                end
            end
        end
        key_in = 4'b0000;
        tick(2);
    endtask

    task automatic test_stall();
        bit ok;
        clear_log();
        build_expected(4'b0010);
        stall = 1'b1;
        tick(2);
        key_in = 4'b0010;
        tick(50);
        nchk++;
        if (q_bytes.size() != 0 || tx_valid !== 1'b1) begin
            nerr++;
            $display("FAIL stall_hold: got %0d starts valid=%b want 0 starts valid=1", q_bytes.size(), tx_valid);
        end
        stall = 1'b0;
        wait_starts(1, 20, ok);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL stall_release: got no tx_start want one");
        end else begin
            nchk++;
            if (start_cyc[0] - ready_rise_cyc != 1 || q_bytes[0] !== exp_q[0]) begin
                nerr++;
                $display("FAIL stall_start: got delay %0d byte %h want 1 %h", start_cyc[0] - ready_rise_cyc, q_bytes[0], exp_q[0]);
            end
        end
        wait_starts(2, 100, ok);
        wait_idle(200, ok);
        nchk++;
        if (q_bytes.size() != 2) begin
            nerr++;
            $display("FAIL stall_count: got %0d bytes want 2", q_bytes.size());
        end
        key_in = 4'b0000;
        tick(2);
    endtask

    task automatic test_random();
        bit         ok;
        logic [3:0] mask;
        int         bad = 0;
        for (int r = 0; r < 20; r++) begin
            clear_log();
            frame_len = $urandom_range(3, 12);
            mask = 4'($urandom_range(1, 15));
            build_expected(mask);
            key_in = mask;
            wait_starts(exp_q.size(), 400, ok);
            wait_idle(200, ok);
            nchk++;
            if (q_bytes.size() != exp_q.size()) begin
                nerr++;
                $display("FAIL rand_count r%0d mask=%b: got %0d want %0d", r, mask, q_bytes.size(), exp_q.size());
            end else begin
                bad = 0;
                for (int i = 0; i < exp_q.size(); i++)
                    if (q_bytes[i] !== exp_q[i]) bad++;
                nchk++;
                if (bad != 0) begin
                    nerr++;
                    $display("FAIL rand_order r%0d mask=%b: %0d bytes differ, first got %h want %h", r, mask, bad, q_bytes[0], exp_q[0]);
                end
            end
            key_in = 4'b0000;
            tick($urandom_range(1, 4));
        end
        nchk++;
        if (overrun !== 4'b0000) begin
            nerr++;
            $display("FAIL rand_overrun: got %b want 0000", overrun);
        end
        frame_len = 10;
    endtask

    task automatic test_overrun();
        bit ok;
        clear_log();
        build_expected(4'b0001);
        build_expected(4'b0010);
        key_in = 4'b0001;
        wait_starts(1, 100, ok);
        key_in = 4'b0011;
        tick(2);
        key_in = 4'b0001;
        tick(2);
        key_in = 4'b0011;
        tick(1);
        wait_starts(4, 400, ok);
        wait_idle(200, ok);
        tick(20);
        nchk++;
        if (overrun !== 4'b0010) begin
            nerr++;
            $display("FAIL overrun_flag: got %b want 0010", overrun);
        end
        nchk++;
        if (q_bytes.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL overrun_count: got %0d want %0d", q_bytes.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                nchk++;
                if (q_bytes[i] !== exp_q[i]) begin
                    nerr++;
                    $display("FAIL overrun_byte%0d: got %h want %h", i, q_bytes[i], exp_q[i]);
                end
            end
        end
        key_in = 4'b0000;
        tick(2);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        clear_log();
        key_in = 4'b0001;
        wait_starts(1, 100, ok);
        key_in = 4'b0101;
        tick(2);
        key_in = 4'b0000;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mptr = 3;
        nchk++;
        if (tx_start !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || overrun !== 4'b0000) begin
            nerr++;
            $display("FAIL midreset_outputs: start=%b valid=%b data=%h ovr=%b want 0 0 00 0000", tx_start, tx_valid, tx_data, overrun);
        end
        wait_idle(100, ok);
        tick(30);
        nchk++;
        if (busy || done_cyc < start_cyc[0]) begin
            nerr++;
            $display("FAIL midreset_uart: busy=%b done_cyc=%0d start=%0d want late tx_done seen", busy, done_cyc, start_cyc[0]);
        end
        nchk++;
        if (q_bytes.size() != 1 || tx_valid !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_quiet: got %0d starts valid=%b want 1 start valid=0", q_bytes.size(), tx_valid);
        end
    endtask

    initial begin
        key_in = 4'b0000;
        rst    = 1'b1;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_round_robin();
        test_stall();
        test_random();
        test_overrun();
        test_reset_midframe();
        nchk++;
        if (proto_viol != 0) begin
            nerr++;
            $display("FAIL tx_protocol: got %0d bad tx_start pulses want 0", proto_viol);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
